// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared constants for the instruction fetch stage: datapath widths, the PC
// increment and the default reset fetch address. Also provides the PC
// sequencing helper used by the top level.
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int XLEN    = 32;
   localparam int INSTR_W = 32;

   localparam logic [XLEN-1:0] PC_STEP          = 32'd4;
   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // Sequential fetch address; wraps naturally from 32'hFFFF_FFFC to 0.
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Parameterised synchronous FIFO with push, pop and flush. Used both as the
// in-flight address queue and as the {PC, instruction} output buffer.
//
// Ports
//   clk      in   rising-edge clock
//   rst_n    in   synchronous active-low reset (control state only)
//   flush_i  in   discard all entries this cycle (wins over push/pop)
//   push_i   in   write data_i (ignored when full)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   remove head entry (ignored when empty)
//   data_o   out  head entry (undefined content when empty)
//   count_o  out  number of stored entries
//   empty_o  out  no entries stored
//   full_o   out  DEPTH entries stored
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] data_o,
   output logic [CNT_W-1:0] count_o,
   output logic             empty_o,
   output logic             full_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q;
   logic [PTR_W-1:0] rd_ptr_q;
   logic [CNT_W-1:0] count_q;
   logic             do_push;
   logic             do_pop;

   // Pointer wrap that also works for non-power-of-two depths.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(DEPTH - 1)) begin
         return '0;
      end
      return p + PTR_W'(1);
   endfunction

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CNT_W'(DEPTH));
   assign count_o = count_q;
   assign data_o  = mem_q[rd_ptr_q];
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr_q <= next_ptr(wr_ptr_q);
         end
         if (do_pop) begin
            rd_ptr_q <= next_ptr(rd_ptr_q);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CNT_W'(1);
            2'b01:   count_q <= count_q - CNT_W'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage carries no reset; the pointers define which entries are live.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage. Generates the PC, issues word requests to
// instruction memory, pairs each returned word with its PC and buffers the
// pair for the fetch/decode register. Absorbs memory latency and downstream
// stalls, and discards wrong-path fetches on a redirect from execute.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   stall        in   downstream not accepting this cycle
//   redirect     in   taken branch/jump: flush and restart at redirect_pc
//   redirect_pc  in   restart address (bits [1:0] ignored)
//   imem_req     out  fetch request valid
//   imem_addr    out  word-aligned fetch address
//   imem_gnt     in   request accepted when imem_req & imem_gnt
//   imem_rvalid  in   response word valid (in request order)
//   imem_rdata   in   response word
//   instr_valid  out  instruction/PC pair valid
//   instruction  out  fetched word (0 when buffer empty)
//   PC           out  address of instruction (0 when buffer empty)
// -----------------------------------------------------------------------------
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT,
   parameter int          MAX_OUTSTANDING = 2,
   parameter int          FIFO_DEPTH      = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instruction,
   output logic [31:0] PC
);

   localparam int AQ_CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int OF_CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int DROP_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam int OF_W     = XLEN + INSTR_W;

   logic [XLEN-1:0]     fetch_pc_q, fetch_pc_d;
   logic [DROP_W-1:0]   drop_q, drop_d;

   logic [XLEN-1:0]     aq_head;
   logic [AQ_CNT_W-1:0] aq_count;
   logic                aq_empty, aq_full;

   logic [OF_W-1:0]     of_head;
   logic [OF_CNT_W-1:0] of_count;
   logic                of_empty, of_full;

   logic [31:0]         outstanding;
   logic [31:0]         occupancy;
   logic                show;
   logic                pop;
   logic                accept;
   logic                resp;
   logic                resp_keep;
   logic                unused_bits;

   // Every accepted request lives either in the address queue (live path) or
   // in the drop counter (wrong path), so the in-flight count is their sum.
   assign outstanding = 32'(aq_count) + 32'(drop_q);

   assign show        = rst_n & ~of_empty;
   assign instr_valid = show & ~redirect;
   assign pop         = instr_valid & ~stall;

   // Reserve buffer space for every in-flight word so a response never finds
   // the output FIFO full.
   assign occupancy = outstanding + 32'(of_count) - 32'(pop);
   assign imem_req  = rst_n & ~redirect
                    & (outstanding < 32'(MAX_OUTSTANDING))
                    & (occupancy < 32'(FIFO_DEPTH));
   assign imem_addr = fetch_pc_q;
   assign accept    = imem_req & imem_gnt;

   // Responses with nothing in flight are spurious and ignored.
   assign resp      = imem_rvalid & (outstanding != 32'd0);
   assign resp_keep = resp & (drop_q == '0);

   assign PC          = show ? of_head[OF_W-1:INSTR_W] : '0;
   assign instruction = show ? of_head[INSTR_W-1:0]    : '0;

   // Occupancy is bounded by the issue gating, so the full flags are not
   // needed; the low redirect bits are forced to zero.
   assign unused_bits = ^{of_full, aq_full, aq_empty, redirect_pc[1:0]};

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      drop_d     = drop_q;
      if (redirect) begin
         fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
         // Everything still in flight after this cycle's response is stale.
         drop_d     = DROP_W'(outstanding - 32'(resp));
      end else begin
         if (accept) begin
            fetch_pc_d = next_pc(fetch_pc_q);
         end
         if (resp && (drop_q != '0)) begin
            drop_d = drop_q - DROP_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fetch_pc_q <= RESET_PC;
         drop_q     <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         drop_q     <= drop_d;
      end
   end

   // Issued PCs awaiting their response word.
   fetch_fifo #(
      .WIDTH (XLEN),
      .DEPTH (MAX_OUTSTANDING)
   ) u_addr_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect),
      .push_i  (accept),
      .data_i  (fetch_pc_q),
      .pop_i   (resp_keep),
      .data_o  (aq_head),
      .count_o (aq_count),
      .empty_o (aq_empty),
      .full_o  (aq_full)
   );

   // {PC, instruction} pairs for the fetch/decode register.
   fetch_fifo #(
      .WIDTH (OF_W),
      .DEPTH (FIFO_DEPTH)
   ) u_out_q (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (redirect),
      .push_i  (resp_keep),
      .data_i  ({aq_head, imem_rdata}),
      .pop_i   (pop),
      .data_o  (of_head),
      .count_o (of_count),
      .empty_o (of_empty),
      .full_o  (of_full)
   );

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, stall, redirect;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_gnt, imem_rvalid, instr_valid;
   logic [31:0] imem_addr, imem_rdata, instruction, PC;

   logic        imem_req2, imem_rvalid2, instr_valid2;
   logic [31:0] imem_addr2, imem_rdata2, instruction2, PC2;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int lat   = 1;
   int popped = 0;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   mreq_t       mq[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp2_q[$];

   fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_OUTSTANDING(2), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
      .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instruction(instruction), .PC(PC)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MAX_OUTSTANDING(2), .FIFO_DEPTH(4)) dut2 (
      .clk(clk), .rst_n(rst_n), .stall(1'b0), .redirect(1'b0),
      .redirect_pc(32'h0), .imem_req(imem_req2), .imem_addr(imem_addr2),
      .imem_gnt(1'b1), .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
      .instr_valid(instr_valid2), .instruction(instruction2), .PC(PC2)
   );

   // Memory contents: an address-derived pattern.
   function automatic logic [31:0] memword(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hDEAD_BEEF;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s at %0t: got %h want %h", name, $time, act, expv);
      end
   endtask

   // ---------------- memory models (observe at negedge, drive after posedge)
   logic        n_acc = 1'b0, n_rv = 1'b0, n_rst = 1'b0, n_acc2 = 1'b0;
   logic [31:0] n_addr = '0, n_addr2 = '0;

   always @(negedge clk) begin
      n_acc   = imem_req & imem_gnt;
      n_addr  = imem_addr;
      n_rv    = imem_rvalid;
      n_rst   = rst_n;
      n_acc2  = imem_req2;
      n_addr2 = imem_addr2;
   end

   initial begin
      imem_rvalid  = 1'b0;
      imem_rdata   = '0;
      imem_rvalid2 = 1'b0;
      imem_rdata2  = '0;
   end

   always @(posedge clk) begin
      #1;
      cyc++;
      if (!n_rst) begin
         mq.delete();
      end else begin
         if (n_rv && mq.size() > 0) void'(mq.pop_front());
         if (n_acc) mq.push_back('{addr: n_addr, due: cyc + lat - 1});
      end
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (mq.size() > 0) begin
         if (mq[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memword(mq[0].addr);
         end
      end
      imem_rvalid2 = n_acc2 & n_rst;
      imem_rdata2  = memword(n_addr2);
   end

   // ---------------- scoreboard monitor
   logic        hold_v = 1'b0;
   logic [31:0] hold_pc = '0, hold_ins = '0;

   always @(negedge clk) begin
      logic [31:0] e;
      logic [31:0] e2;
      if (hold_v && rst_n && !redirect) begin
         check("stall_hold_valid", {31'b0, instr_valid}, 32'd1);
         check("stall_hold_pc", PC, hold_pc);
         check("stall_hold_instr", instruction, hold_ins);
      end
      hold_v   = rst_n & instr_valid & stall;
      hold_pc  = PC;
      hold_ins = instruction;
      if (rst_n && instr_valid && !stall) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid at %0t: got PC %h want no output", $time, PC);
         end else begin
            e = exp_q.pop_front();
            check("pc", PC, e);
            check("instr", instruction, memword(e));
            popped++;
         end
      end
      if (rst_n && instr_valid2 && exp2_q.size() != 0) begin
         e2 = exp2_q.pop_front();
         check("wrap_pc", PC2, e2);
         check("wrap_instr", instruction2, memword(e2));
      end
   end

   // ---------------- stimulus
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   task automatic load_path(input logic [31:0] base);
      exp_q.delete();
      for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(i * 4));
   endtask

   initial begin
      int  p0;
      bit  found;
      rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b1;
      load_path(32'h0);
      exp2_q.push_back(32'hFFFF_FFF8);
      exp2_q.push_back(32'hFFFF_FFFC);
      exp2_q.push_back(32'h0000_0000);

      // Reset state
      repeat (3) step();
      peek();
      check("rst_req", {31'b0, imem_req}, 32'd0);
      check("rst_valid", {31'b0, instr_valid}, 32'd0);
      check("rst_instr", instruction, 32'd0);
      check("rst_pc", PC, 32'd0);
      check("rst_addr", imem_addr, 32'h0);
      check("rst_addr2", imem_addr2, 32'hFFFF_FFF8);

      // Streaming from reset, 1-cycle memory
      step(); rst_n = 1'b1;                    // cycle 0
      peek();
      check("c0_req", {31'b0, imem_req}, 32'd1);
      check("c0_addr", imem_addr, 32'h0);
      step(); peek();                          // cycle 1
      check("c1_valid", {31'b0, instr_valid}, 32'd0);
      check("c1_addr", imem_addr, 32'h4);
      step(); peek();                          // cycle 2
      check("c2_valid", {31'b0, instr_valid}, 32'd1);
      check("c2_pc", PC, 32'h0);
      repeat (6) step();                       // cycle 8
      check("popped_before_stall", 32'(popped), 32'd6);

      // Stall for 6 cycles
      stall = 1'b1;
      for (int i = 0; i < 6; i++) begin
         peek();
         if (i >= 2) check("stall_req_low", {31'b0, imem_req}, 32'd0);
         step();
      end
      stall = 1'b0;                            // cycle 14
      repeat (6) step();                       // cycle 20
      check("popped_after_stall", 32'(popped), 32'd12);

      // Redirect with two requests outstanding, 3-cycle memory
      lat = 3;
      found = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step(); #1;
         if (mq.size() == 2) begin
            found = 1'b1;
            break;
         end
      end
      check("two_outstanding_seen", {31'b0, found}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0000_0103;
      load_path(32'h0000_0100);
      p0 = popped;
      peek();
      check("redir_valid", {31'b0, instr_valid}, 32'd0);
      check("redir_req", {31'b0, imem_req}, 32'd0);
      step(); redirect = 1'b0;
      peek();
      check("redir_addr", imem_addr, 32'h0000_0100);
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         if (imem_req && imem_gnt) begin
            found = 1'b1;
            break;
         end
         step(); peek();
      end
      check("redir_req_issued", {31'b0, found}, 32'd1);
      check("redir_req_addr", imem_addr, 32'h0000_0100);
      repeat (12) step();
      lat = 1;
      repeat (8) step();
      check("redir_path_delivered", {31'b0, (popped - p0) >= 6}, 32'd1);

      // Redirect coinciding with a response and a pop
      found = 1'b0;
      for (int k = 0; k < 10; k++) begin
         #1;
         if (imem_rvalid && instr_valid && !stall) begin
            found = 1'b1;
            break;
         end
         step();
      end
      check("coincide_seen", {31'b0, found}, 32'd1);
      redirect = 1'b1; redirect_pc = 32'h0000_0200;
      load_path(32'h0000_0200);
      peek();
      check("co_valid", {31'b0, instr_valid}, 32'd0);
      check("co_req", {31'b0, imem_req}, 32'd0);
      step(); redirect = 1'b0;
      peek();
      check("co_fifo_empty", {31'b0, instr_valid}, 32'd0);
      check("co_next_req", {31'b0, imem_req}, 32'd1);
      check("co_next_addr", imem_addr, 32'h0000_0200);
      step(); peek();
      check("co_n2_valid", {31'b0, instr_valid}, 32'd0);
      step(); peek();
      check("co_n3_valid", {31'b0, instr_valid}, 32'd1);
      check("co_n3_pc", PC, 32'h0000_0200);

      // Mid-stream reset with requests in flight
      lat = 3;
      repeat (5) step();
      rst_n = 1'b0;
      load_path(32'h0);
      peek();
      check("mid_rst_req", {31'b0, imem_req}, 32'd0);
      check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
      check("mid_rst_instr", instruction, 32'd0);
      check("mid_rst_pc", PC, 32'd0);
      step(); rst_n = 1'b1;
      peek();
      check("restart_req", {31'b0, imem_req}, 32'd1);
      check("restart_addr", imem_addr, 32'h0);
      p0 = popped;
      repeat (15) step();
      check("restart_delivered", {31'b0, (popped - p0) >= 4}, 32'd1);
      check("wrap_all_seen", 32'(exp2_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage: generates the program counter, issues word requests to instruction memory, pairs each returned word with its PC, and buffers the pair for the fetch/decode pipeline register. Sits directly upstream of the fetch latch. Absorbs variable memory latency and downstream stalls, and discards wrong-path fetches on a branch/jump redirect from execute.

## Interface
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory requests.
- FIFO_DEPTH, 4: output buffer entries; must be ≥ MAX_OUTSTANDING.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  downstream not accepting this cycle.
- redirect  in  1  taken branch/jump; flush and restart.
- redirect_pc  in  32  restart address; bits [1:0] ignored (forced 0).
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_gnt  in  1  request accepted when imem_req & imem_gnt.
- imem_rvalid  in  1  response word valid; responses in request order.
- imem_rdata  in  32  response word.
- instr_valid  out  1  instruction/PC pair valid.
- instruction  out  32  fetched word.
- PC  out  32  address of instruction.

## Operation
- State: fetch_pc, outstanding count (0..MAX_OUTSTANDING), drop count, address queue (depth MAX_OUTSTANDING, issued PCs), output FIFO (FIFO_DEPTH, {PC, instruction}).
- Issue: imem_req = !redirect & (outstanding < MAX_OUTSTANDING) & (outstanding + fifo_count − pop < FIFO_DEPTH). imem_addr = fetch_pc. On accept: push fetch_pc to address queue, fetch_pc += 4 (mod 2^32, 32'hFFFF_FFFC wraps to 0), outstanding++.
- Response: on imem_rvalid, outstanding--. If drop count > 0: drop count--, discard word, pop address queue. Otherwise push {address-queue head, imem_rdata} into FIFO, pop address queue.
- Output: instr_valid = !fifo_empty & !redirect; instruction/PC = FIFO head, 0 when empty. Pop when instr_valid & !stall.
- Redirect (priority over everything): fetch_pc ← {redirect_pc[31:2], 2'b00}; FIFO and address queue cleared; drop count ← outstanding after this cycle's response and accept are accounted (a response arriving this cycle is discarded); no request issued; no pop.
- imem_rvalid with outstanding = 0: ignored, no state change (verification flags as error).
- Simultaneous accept + response + pop: all take effect; counts net.

## Timing
- Reset (rst_n low at clock edge): fetch_pc = RESET_PC, outstanding = 0, drop = 0, queues empty. Outputs during/after reset: imem_req 0 while rst_n low, imem_addr = RESET_PC, instr_valid 0, instruction 0, PC 0. First request in first cycle with rst_n high. Reset mid-operation abandons in-flight requests; memory shares rst_n.
- Response to instr_valid: 1 cycle (registered into FIFO). With 1-cycle memory and imem_gnt tied high: request at cycle N, instr_valid at N+2, then one instruction per cycle sustained.
- Redirect at cycle N: first redirected request at N+1; no wrong-path instr_valid from N onward.
- stall holds outputs stable; FIFO fills, then imem_req drops; no word lost.

## Structure
- Shared package fetch_pkg: XLEN = 32, INSTR_W = 32, PC_STEP = 4, default RESET_PC.
- One sub-module: fetch_fifo (parameterised width/depth synchronous FIFO, push/pop/flush, count, empty/full), instantiated twice (address queue width 32, output FIFO width 64).

## Test plan
- Reset release, RESET_PC = 0, 1-cycle memory, gnt high, no stall -> instr_valid from cycle 2, PCs 0,4,8,C… one per cycle, words match memory.
- stall held 6 cycles mid-stream -> outputs frozen, imem_req drops after FIFO full (4), resumes without gap or duplicate PC.
- redirect to 0x0000_0103 while 2 requests outstanding (3-cycle memory) -> both responses discarded, next request address 0x0000_0100, first valid PC 0x100.
- redirect coincident with imem_rvalid and a FIFO pop -> that word dropped, FIFO empty, no instr_valid that cycle.
- RESET_PC = 32'hFFFF_FFF8 -> PCs FFFF_FFF8, FFFF_FFFC, 0000_0000.
- rst_n low for one cycle mid-stream with requests outstanding -> all outputs return to reset values, fetch restarts at RESET_PC.
